// File: rtl/tm1638_frame_packer.sv
// Turns a segment/LED snapshot into a 19-byte TM1638 frame (0x40 | 0xC0 + 16 data | ctrl); first byte one cycle after i_Valid.
// o_Data/o_Last hold while i_Ready is low; updates arriving mid-frame wait in a one-deep pending buffer (newest wins).
module tm1638_frame_packer #(
    parameter int BRIGHTNESS = 7,
    parameter int DISPLAY_ON = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [63:0] i_Segments,
    input  logic [7:0]  i_Leds,
    input  logic        i_Valid,
    output logic [7:0]  o_Data,
    output logic        o_Valid,
    output logic        o_Last,
    input  logic        i_Ready,
    output logic        o_Busy
);

    typedef enum logic [2:0] {IDLE, MODE, ADDR, DATA, CTRL} state_t;

    localparam logic [2:0] BRIGHT_BITS = 3'(BRIGHTNESS);
    localparam logic [7:0] CTRL_BYTE   = {4'b1000, (DISPLAY_ON != 0), BRIGHT_BITS};

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_index;
    logic [63:0] r_snap_seg;
    logic [7:0]  r_snap_led;
    logic [63:0] r_pend_seg;
    logic [7:0]  r_pend_led;
    logic        r_pending;
    logic        w_handshake;
    logic [2:0]  w_grid;

    assign w_grid      = r_index[3:1];
    assign w_handshake = o_Valid && i_Ready;
    assign o_Busy      = (r_state != IDLE);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_Data  = 8'h00;
        o_Valid = 1'b0;
        o_Last  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_Valid || r_pending) w_next = MODE;
            end
            MODE: begin
                o_Valid = 1'b1;
                o_Data  = 8'h40;
                o_Last  = 1'b1;
                if (i_Ready) w_next = ADDR;
            end
            ADDR: begin
                o_Valid = 1'b1;
                o_Data  = 8'hC0;
                if (i_Ready) w_next = DATA;
            end
            DATA: begin
                // Even index carries the grid's segment byte, odd index its LED bit.
                o_Valid = 1'b1;
                o_Data  = r_index[0] ? {7'b0, r_snap_led[w_grid]}
                                     : r_snap_seg[{w_grid, 3'b000} +: 8];
                o_Last  = (r_index == 4'd15);
                if (i_Ready && (r_index == 4'd15)) w_next = CTRL;
            end
            CTRL: begin
                o_Valid = 1'b1;
                o_Data  = CTRL_BYTE;
                o_Last  = 1'b1;
                if (i_Ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_index    <= 4'd0;
            r_snap_seg <= 64'd0;
            r_snap_led <= 8'd0;
            r_pend_seg <= 64'd0;
            r_pend_led <= 8'd0;
            r_pending  <= 1'b0;
        end else begin
            if (r_state == ADDR && w_handshake) begin
                r_index <= 4'd0;
            end else if (r_state == DATA && w_handshake) begin
                r_index <= r_index + 4'd1;
            end

            if (r_state == IDLE) begin
                if (i_Valid) begin
                    r_snap_seg <= i_Segments;
                    r_snap_led <= i_Leds;
                end
                r_pending <= 1'b0;
            end else if (r_state == CTRL && w_handshake) begin
                // Frame is done with the snapshot: load the queued update and keep
                // pending set so IDLE launches the follow-up frame.
                if (i_Valid) begin
                    r_snap_seg <= i_Segments;
                    r_snap_led <= i_Leds;
                    r_pending  <= 1'b1;
                end else if (r_pending) begin
                    r_snap_seg <= r_pend_seg;
                    r_snap_led <= r_pend_led;
                end
            end else if (i_Valid) begin
                r_pend_seg <= i_Segments;
                r_pend_led <= i_Leds;
                r_pending  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tm1638_frame_packer.sv
// Directed bench for tm1638_frame_packer: default instance plus a BRIGHTNESS=2/DISPLAY_ON=0 instance.
module tb_tm1638_frame_packer;

    typedef struct packed {
        logic [7:0]  d;
        logic        l;
        logic [31:0] c;
    } rec_t;

    localparam logic [63:0] SEG_A  = 64'h0706050403020100;
    localparam logic [63:0] SEG_FF = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] SEG_11 = 64'h1111111111111111;
    localparam logic [63:0] SEG_B  = 64'hDEADBEEF01234567;
    localparam logic [63:0] SEG_C  = 64'h89ABCDEFFEDCBA98;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic [63:0] i_Segments = 64'd0;
    logic [7:0]  i_Leds = 8'd0;
    logic        i_Valid = 1'b0;
    logic        i_Ready = 1'b1;
    logic [7:0]  o_Data;
    logic        o_Valid;
    logic        o_Last;
    logic        o_Busy;

    logic        valid2 = 1'b0;
    logic [7:0]  data2;
    logic        vld2;
    logic        last2;
    logic        busy2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          trig_cyc = 0;
    int          n_stalls = 0;
    int          cnt2     = 0;
    logic [7:0]  ctrl2_seen = 8'd0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_d = 8'd0;
    logic        stall_l = 1'b0;
    logic        stall_mode = 1'b0;
    logic [15:0] rdy_pat = 16'b1001_0110_1101_0010;
    rec_t        q[$];

    tm1638_frame_packer dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Segments(i_Segments), .i_Leds(i_Leds),
        .i_Valid(i_Valid), .o_Data(o_Data), .o_Valid(o_Valid), .o_Last(o_Last),
        .i_Ready(i_Ready), .o_Busy(o_Busy)
    );

    tm1638_frame_packer #(.BRIGHTNESS(2), .DISPLAY_ON(0)) dut2 (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Segments(i_Segments), .i_Leds(i_Leds),
        .i_Valid(valid2), .o_Data(data2), .o_Valid(vld2), .o_Last(last2),
        .i_Ready(1'b1), .o_Busy(busy2)
    );

    always #5 i_Clk = ~i_Clk;
    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs settle at these negedges exactly as the next rising edge will see them.
    always @(negedge i_Clk) begin
        rec_t r;
        if (!i_Rst && o_Valid && i_Ready) begin
            r.d = o_Data;
            r.l = o_Last;
            r.c = 32'(cyc);
            q.push_back(r);
        end
        if (!i_Rst && i_Valid) trig_cyc = cyc;
        if (stall_prev && !i_Rst && o_Valid) begin
            check("stall_data", 32'(o_Data), 32'(stall_d));
            check("stall_last", 32'(o_Last), 32'(stall_l));
        end
        stall_prev = !i_Rst && o_Valid && !i_Ready;
        stall_d    = o_Data;
        stall_l    = o_Last;
        if (stall_prev) n_stalls++;
        if (!i_Rst && vld2) begin
            cnt2++;
            if (cnt2 == 19) ctrl2_seen = data2;
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
        if (stall_mode) begin
            i_Ready = rdy_pat[15];
            rdy_pat = {rdy_pat[14:0], rdy_pat[15]};
        end
    endtask

    task automatic pulse_valid(input logic [63:0] seg, input logic [7:0] led);
        i_Segments = seg;
        i_Leds     = led;
        i_Valid    = 1'b1;
        tick();
        i_Valid    = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int b = 0;
        while (q.size() < n && b < budget) begin
            tick();
            b++;
        end
        if (q.size() < n) check("timeout_bytes", 32'(q.size()), 32'(n));
    endtask

    function automatic logic [7:0] exp_byte(input int k, input logic [63:0] seg,
                                            input logic [7:0] led, input logic [7:0] ctrl);
        int i;
        i = k - 2;
        if (k == 0)  return 8'h40;
        if (k == 1)  return 8'hC0;
        if (k == 18) return ctrl;
        if (i % 2 == 0) return seg[6'((i / 2) * 8) +: 8];
        return {7'b0, led[3'(i / 2)]};
    endfunction

    task automatic check_frame(input string tag, input int base, input logic [63:0] seg,
                               input logic [7:0] led);
        check({tag, "_len"}, 32'(q.size() >= base + 19), 32'd1);
        for (int k = 0; k < 19; k++) begin
            if (base + k < q.size()) begin
                check($sformatf("%s_d%0d", tag, k), 32'(q[base + k].d),
                      32'(exp_byte(k, seg, led, 8'h8F)));
                check($sformatf("%s_l%0d", tag, k), 32'(q[base + k].l),
                      32'(k == 0 || k >= 17));
            end
        end
    endtask

    initial begin
        // Frame for SEG_A with LEDs 0xA5 (bit g = LED of grid g), written out by hand.
        logic [7:0] golden [19] = '{8'h40, 8'hC0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h01,
                                    8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h01, 8'h06, 8'h00,
                                    8'h07, 8'h01, 8'h8F};
        logic       golden_l [19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b1, 1'b1};
        int base;
        int b;

        // Reset, with i_Valid asserted throughout (must be ignored).
        i_Valid = 1'b1;
        valid2  = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(o_Valid), 32'd0);
        check("rst_last",  32'(o_Last),  32'd0);
        check("rst_data",  32'(o_Data),  32'h00);
        check("rst_busy",  32'(o_Busy),  32'd0);
        i_Rst   = 1'b0;
        i_Valid = 1'b0;
        valid2  = 1'b0;
        tick();
        check("post_rst_busy", 32'(o_Busy), 32'd0);
        check("post_rst_bytes", 32'(q.size()), 32'd0);

        // Ready high: 19 bytes back to back, one cycle after the trigger.
        base   = q.size();
        valid2 = 1'b1;
        pulse_valid(SEG_A, 8'hA5);
        valid2 = 1'b0;
        check("t1_busy", 32'(o_Busy), 32'd1);
        wait_bytes(base + 19, 60);
        if (q.size() >= base + 19) begin
            for (int k = 0; k < 19; k++) begin
                check($sformatf("t1_d%0d", k), 32'(q[base + k].d), 32'(golden[k]));
                check($sformatf("t1_l%0d", k), 32'(q[base + k].l), 32'(golden_l[k]));
            end
            check("t1_first_lat", q[base].c - 32'(trig_cyc), 32'd1);
            check("t1_consecutive", q[base + 18].c - q[base].c, 32'd18);
        end
        repeat (4) tick();
        check("t1_idle_busy", 32'(o_Busy), 32'd0);
        check("t1_no_extra", 32'(q.size()), 32'(base + 19));
        check("ctrl_b2_off", 32'(ctrl2_seen), 32'h82);
        check("ctrl_b2_count", 32'(cnt2), 32'd19);

        // Pseudo-random ready: same bytes, stable through every stall.
        base       = q.size();
        stall_mode = 1'b1;
        pulse_valid(SEG_A, 8'hA5);
        wait_bytes(base + 19, 200);
        stall_mode = 1'b0;
        i_Ready    = 1'b1;
        check_frame("t2", base, SEG_A, 8'hA5);
        check("t2_stalls_seen", 32'(n_stalls > 0), 32'd1);
        repeat (4) tick();

        // Two updates mid-frame: only the newest (0x11) gets a frame.
        base = q.size();
        pulse_valid(SEG_A, 8'h3C);
        wait_bytes(base + 5, 40);
        pulse_valid(SEG_FF, 8'hFF);
        wait_bytes(base + 10, 40);
        pulse_valid(SEG_11, 8'h11);
        wait_bytes(base + 38, 120);
        repeat (6) tick();
        check("t3_total", 32'(q.size()), 32'(base + 38));
        check_frame("t3_f1", base, SEG_A, 8'h3C);
        check_frame("t3_f2", base + 19, SEG_11, 8'h11);
        if (q.size() >= base + 20)
            check("t3_gap", q[base + 19].c - q[base + 18].c, 32'd2);

        // i_Valid on the CTRL handshake edge: one IDLE cycle, then a new frame.
        base = q.size();
        pulse_valid(SEG_A, 8'h0F);
        b = 0;
        while (q.size() - base < 18 && b < 60) begin
            tick();
            b++;
        end
        check("t4_at_ctrl", 32'(q.size() - base), 32'd18);
        check("t4_ctrl_shown", 32'(o_Data), 32'h8F);
        pulse_valid(SEG_B, 8'h5A);
        check("t4_gap_busy", 32'(o_Busy), 32'd0);
        check("t4_gap_valid", 32'(o_Valid), 32'd0);
        tick();
        check("t4_restart_busy", 32'(o_Busy), 32'd1);
        check("t4_restart_data", 32'(o_Data), 32'h40);
        wait_bytes(base + 38, 80);
        check_frame("t4_f1", base, SEG_A, 8'h0F);
        check_frame("t4_f2", base + 19, SEG_B, 8'h5A);
        repeat (4) tick();

        // Reset in DATA index 7 aborts; i_Valid during reset is ignored.
        base = q.size();
        pulse_valid(SEG_B, 8'hF0);
        b = 0;
        while (q.size() - base < 9 && b < 60) begin
            tick();
            b++;
        end
        check("t5_idx7", 32'(o_Data), 32'(exp_byte(9, SEG_B, 8'hF0, 8'h8F)));
        i_Rst      = 1'b1;
        i_Valid    = 1'b1;
        i_Segments = SEG_C;
        tick();
        check("t5_rst_valid", 32'(o_Valid), 32'd0);
        check("t5_rst_busy",  32'(o_Busy),  32'd0);
        check("t5_rst_data",  32'(o_Data),  32'h00);
        i_Rst   = 1'b0;
        i_Valid = 1'b0;
        tick();
        check("t5_post_busy", 32'(o_Busy), 32'd0);
        check("t5_aborted", 32'(q.size()), 32'(base + 9));
        base = q.size();
        pulse_valid(SEG_C, 8'h81);
        wait_bytes(base + 19, 60);
        check_frame("t5_new", base, SEG_C, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
